// File: rtl/clk_divider_pkg.sv
// -----------------------------------------------------------------------------
// clk_divider_pkg
// Shared constants and helpers for the clock-enable divider.
//   SYS_CLK_HZ  : system clock frequency (50 MHz)
//   SEC_TICK_HZ : seconds timebase rate (1 Hz)
//   cnt_width() : counter width needed to hold 0 .. div-1
// -----------------------------------------------------------------------------
package clk_divider_pkg;

   localparam int unsigned SYS_CLK_HZ  = 50_000_000;
   localparam int unsigned SEC_TICK_HZ = 1;

   // At least one bit, even for degenerate divisors, so ports stay legal.
   function automatic int unsigned cnt_width(input int unsigned div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage : clk_divider_pkg

// File: rtl/clk_divider_mod_n_counter.sv
// -----------------------------------------------------------------------------
// mod_n_counter
// Free-running modulo-N counter with a combinational terminal-count flag.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low reset (count -> 0)
//   count : current count, 0 .. N-1
//   wrap  : high while count == N-1 (the next edge returns to 0)
// -----------------------------------------------------------------------------
module mod_n_counter
   import clk_divider_pkg::*;
#(
   parameter int unsigned N = 5,
   parameter int unsigned W = cnt_width(N)
) (
   input  logic         clk,
   input  logic         reset,
   output logic [W-1:0] count,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   generate
      if (N < 2) begin : g_bad_n
         $error("mod_n_counter: N must be >= 2");
      end
   endgenerate

   assign wrap = (count_q == LAST);

   // Wrap to zero on the terminal count so the counter never reaches N.
   always_comb begin
      count_d = count_q + W'(1);
      if (wrap) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : mod_n_counter

// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
// Clock-enable generator: divides clk_50mhz down to a single-cycle tick every
// DIV = CLK_FREQ_HZ / TICK_HZ cycles. No derived clock is produced; consumers
// use tick_1hz as an enable in the clk_50mhz domain.
// Optional build macro: CLK_DIVIDER_SQUARE_EN adds clk_1hz_sq, a registered
// 50% duty square wave (data signal, never a clock).
// Ports:
//   clk_50mhz  : system clock
//   reset      : asynchronous, active-low reset
//   tick_1hz   : one-clock-wide pulse every DIV cycles, straight from a flop
//   clk_1hz_sq : square wave, low floor(DIV/2) cycles then high (macro only)
// -----------------------------------------------------------------------------
module clk_divider
   import clk_divider_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = SYS_CLK_HZ,
   parameter int unsigned TICK_HZ     = SEC_TICK_HZ
) (
   input  logic clk_50mhz,
   input  logic reset,
`ifdef CLK_DIVIDER_SQUARE_EN
   output logic clk_1hz_sq,
`endif
   output logic tick_1hz
);

   localparam int unsigned DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int unsigned CNT_W = cnt_width(DIV);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("clk_divider: DIV = CLK_FREQ_HZ/TICK_HZ must be >= 2");
      end
      if ((CLK_FREQ_HZ % TICK_HZ) != 0) begin : g_bad_ratio
         $error("clk_divider: CLK_FREQ_HZ must be a multiple of TICK_HZ");
      end
   endgenerate

   logic [CNT_W-1:0] cnt;
   logic             wrap;
   logic             tick_q;
   logic             tick_d;

   mod_n_counter #(
      .N (DIV),
      .W (CNT_W)
   ) u_counter (
      .clk   (clk_50mhz),
      .reset (reset),
      .count (cnt),
      .wrap  (wrap)
   );

   // The tick is the registered terminal count: it is high for the cycle that
   // follows the edge on which the counter wraps from DIV-1 to 0.
   assign tick_d = wrap;

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign tick_1hz = tick_q;

`ifdef CLK_DIVIDER_SQUARE_EN
   localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

   logic [CNT_W-1:0] cnt_next;
   logic             sq_q;
   logic             sq_d;

   // Track the value the counter takes at this edge so the square wave is
   // aligned with the count it describes, not one cycle behind it.
   always_comb begin
      cnt_next = cnt + CNT_W'(1);
      if (wrap) begin
         cnt_next = '0;
      end
      sq_d = (cnt_next >= HALF);
   end

   always_ff @(posedge clk_50mhz or negedge reset) begin
      if (!reset) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign clk_1hz_sq = sq_q;
`else
   // The count only feeds the square-wave path; fold it so the net is not
   // left dangling when that path is absent.
   logic cnt_unused;
   assign cnt_unused = ^cnt;
`endif

endmodule : clk_divider

// File: tb/tb_clk_divider.sv
module tb_clk_divider;

   localparam int DIV_A = 5;
   localparam int DIV_B = 6;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic tick_a;
   logic tick_b;
`ifdef CLK_DIVIDER_SQUARE_EN
   logic sq_a;
   logic sq_b;
`endif

   always #10 clk = ~clk;

   clk_divider #(.CLK_FREQ_HZ(5), .TICK_HZ(1)) dut_a (
      .clk_50mhz  (clk),
      .reset      (reset_n),
`ifdef CLK_DIVIDER_SQUARE_EN
      .clk_1hz_sq (sq_a),
`endif
      .tick_1hz   (tick_a)
   );

   clk_divider #(.CLK_FREQ_HZ(12), .TICK_HZ(2)) dut_b (
      .clk_50mhz  (clk),
      .reset      (reset_n),
`ifdef CLK_DIVIDER_SQUARE_EN
      .clk_1hz_sq (sq_b),
`endif
      .tick_1hz   (tick_b)
   );

   typedef struct {
      int kind;
      int exp;
   } exp_t;

   exp_t  sb_q[$];
   string names[6] = '{"tick_a", "cnt_a", "tick_b", "cnt_b", "sq_a", "sq_b"};

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int ma_cnt = 0;
   int mb_cnt = 0;
   int ma_tick = 0;
   int mb_tick = 0;
`ifdef CLK_DIVIDER_SQUARE_EN
   int ma_sq = 0;
   int mb_sq = 0;
`endif
   int edge_no = 0;
   int ticks_a[$];
   int ticks_b[$];

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int observe(input int kind);
      case (kind)
         0: return int'(tick_a);
         1: return int'(dut_a.u_counter.count_q);
         2: return int'(tick_b);
         3: return int'(dut_b.u_counter.count_q);
`ifdef CLK_DIVIDER_SQUARE_EN
         4: return int'(sq_a);
         5: return int'(sq_b);
`endif
         default: return -1;
      endcase
   endfunction

   task automatic push_all();
      exp_t e;
      e.kind = 0; e.exp = ma_tick; sb_q.push_back(e);
      e.kind = 1; e.exp = ma_cnt;  sb_q.push_back(e);
      e.kind = 2; e.exp = mb_tick; sb_q.push_back(e);
      e.kind = 3; e.exp = mb_cnt;  sb_q.push_back(e);
`ifdef CLK_DIVIDER_SQUARE_EN
      e.kind = 4; e.exp = ma_sq;   sb_q.push_back(e);
      e.kind = 5; e.exp = mb_sq;   sb_q.push_back(e);
`endif
   endtask

   task automatic drain(input string phase);
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({phase, ":", names[e.kind]}, observe(e.kind), e.exp);
      end
   endtask

   // One clock period: drive reset at the falling edge, advance the model on
   // the rising edge, compare 1 ns later.
   task automatic cycle(input logic rst_v);
      @(negedge clk);
      reset_n = rst_v;
      if (!rst_v) begin
         ma_cnt = 0; ma_tick = 0;
         mb_cnt = 0; mb_tick = 0;
`ifdef CLK_DIVIDER_SQUARE_EN
         ma_sq = 0; mb_sq = 0;
`endif
         edge_no = 0;
         #1;
         push_all();
         drain("async");
      end
      @(posedge clk);
      if (rst_v) begin
         edge_no++;
         ma_tick = (ma_cnt == DIV_A - 1) ? 1 : 0;
         ma_cnt  = (ma_cnt == DIV_A - 1) ? 0 : ma_cnt + 1;
         mb_tick = (mb_cnt == DIV_B - 1) ? 1 : 0;
         mb_cnt  = (mb_cnt == DIV_B - 1) ? 0 : mb_cnt + 1;
`ifdef CLK_DIVIDER_SQUARE_EN
         ma_sq = (ma_cnt >= DIV_A / 2) ? 1 : 0;
         mb_sq = (mb_cnt >= DIV_B / 2) ? 1 : 0;
`endif
      end
      push_all();
      #1;
      drain("edge");
      if (tick_a === 1'b1) ticks_a.push_back(edge_no);
      if (tick_b === 1'b1) ticks_b.push_back(edge_no);
   endtask

   task automatic check_ticks(input string phase);
      check({phase, ":a_count"}, ticks_a.size(), 3);
      for (int i = 0; i < 3; i++) begin
         check({phase, ":a_edge"}, (i < ticks_a.size()) ? ticks_a[i] : -1, DIV_A * (i + 1));
      end
      check({phase, ":b_count"}, ticks_b.size(), 2);
      for (int i = 0; i < 2; i++) begin
         check({phase, ":b_edge"}, (i < ticks_b.size()) ? ticks_b[i] : -1, DIV_B * (i + 1));
      end
   endtask

   initial begin
      int guard;

      // reset held low with the clock running
      for (int i = 0; i < 10; i++) cycle(1'b0);

      // release: ticks on edges DIV, 2*DIV, 3*DIV
      ticks_a.delete();
      ticks_b.delete();
      for (int i = 0; i < 16; i++) cycle(1'b1);
      check_ticks("run1");

      // advance to the cycle where cnt_a == 4, then assert reset there
      guard = 0;
      while (ma_cnt != DIV_A - 1 && guard < 10) begin
         cycle(1'b1);
         guard++;
      end
      check("reach_cnt4", int'(dut_a.u_counter.count_q), DIV_A - 1);
      cycle(1'b0);
      check("rst_wins_tick", int'(tick_a), 0);
      cycle(1'b0);

      // full period restarts after release
      ticks_a.delete();
      ticks_b.delete();
      for (int i = 0; i < 16; i++) cycle(1'b1);
      check_ticks("run2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_clk_divider
